// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / clock-enable generator.
// Each channel divides clk by a runtime divisor, emitting a pulse or a 50% square wave.
module tick_gen_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pend
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div;
      logic [CNT_W-1:0] r_sh_div;
      logic             r_mode;
      logic             r_sh_mode;
      logic             r_pend;
      logic             r_tick;
      logic             r_run;

      logic             w_sel;
      logic             w_stopped;
      logic             w_wrap;
      logic [CNT_W-1:0] w_div_m1;
      logic [CNT_W-1:0] w_next_div;
      logic             w_next_mode;

      assign w_sel       = cfg_wr && (cfg_ch == 4'(gi));
      assign w_stopped   = (r_div == '0);
      assign w_div_m1    = r_div - CNT_W'(1);
      // r_run delays counting by one edge so the first wrap lands D edges after enable
      assign w_wrap      = en[gi] && r_run && !w_stopped && (r_cnt == w_div_m1);
      assign w_next_div  = r_pend ? r_sh_div  : r_div;
      assign w_next_mode = r_pend ? r_sh_mode : r_mode;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt     <= '0;
          r_div     <= DEF_DIV;
          r_sh_div  <= DEF_DIV;
          r_mode    <= 1'b0;
          r_sh_mode <= 1'b0;
          r_pend    <= 1'b0;
          r_tick    <= 1'b0;
          r_run     <= 1'b0;
        end else if (!en[gi]) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_run  <= 1'b0;
          r_pend <= 1'b0;
          if (w_sel) begin
            r_div     <= cfg_div;
            r_mode    <= cfg_mode;
            r_sh_div  <= cfg_div;
            r_sh_mode <= cfg_mode;
          end else begin
            r_div  <= w_next_div;
            r_mode <= w_next_mode;
          end
        end else if (sync) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_run  <= 1'b1;
          r_pend <= 1'b0;
          if (w_sel) begin
            r_div     <= cfg_div;
            r_mode    <= cfg_mode;
            r_sh_div  <= cfg_div;
            r_sh_mode <= cfg_mode;
          end else begin
            r_div  <= w_next_div;
            r_mode <= w_next_mode;
          end
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_div  <= w_next_div;
          r_mode <= w_next_mode;
          // a mode switch restarts the output at phase 0 instead of emitting an edge
          if (w_next_mode != r_mode) begin
            r_tick <= 1'b0;
          end else if (r_mode) begin
            r_tick <= ~r_tick;
          end else begin
            r_tick <= 1'b1;
          end
          if (w_sel) begin
            r_sh_div  <= cfg_div;
            r_sh_mode <= cfg_mode;
            r_pend    <= 1'b1;
          end else begin
            r_pend <= 1'b0;
          end
        end else begin
          r_run <= 1'b1;
          if (r_run && !w_stopped) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          r_tick <= (r_mode && !w_stopped) ? r_tick : 1'b0;
          if (w_sel) begin
            r_sh_div  <= cfg_div;
            r_sh_mode <= cfg_mode;
            r_pend    <= 1'b1;
          end
        end
      end

      assign tick[gi] = r_tick;
      assign pend[gi] = r_pend;
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: stimulus queues expected output edges,
// a negedge monitor matches every observed tick/pend change against that queue.
module tb_tick_gen_multi;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int DEF   = 300;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_CH-1:0]  en = '0;
  logic             sync = 1'b0;
  logic             cfg_wr = 1'b0;
  logic [3:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_mode = 1'b0;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  tick_gen_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int ch;
    bit p;
    bit v;
  } ev_t;

  ev_t             q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  bit              mon_on = 1'b0;
  logic [N_CH-1:0] prev_tick = '0;
  logic [N_CH-1:0] prev_pend = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input int ch, input bit p, input bit v);
    ev_t e;
    e.c = c; e.ch = ch; e.p = p; e.v = v;
    q.push_back(e);
  endtask

  task automatic pulses(input int ch, input int first, input int d, input int n);
    for (int k = 0; k < n; k++) begin
      push(first + k * d, ch, 1'b0, 1'b1);
      push(first + k * d + 1, ch, 1'b0, 1'b0);
    end
  endtask

  task automatic squares(input int ch, input int first, input int d, input int n);
    for (int k = 0; k < n; k++) push(first + k * d, ch, 1'b0, (k % 2) == 0);
  endtask

  task automatic cfg(input int ch, input int div, input bit mode);
    cfg_wr = 1'b1; cfg_ch = 4'(ch); cfg_div = CNT_W'(div); cfg_mode = mode;
    step();
    cfg_wr = 1'b0;
  endtask

  // Monitor: every change on tick/pend must match a queued expectation for this cycle
  always @(negedge clk) begin
    logic cur;
    logic prv;
    int   idx;
    if (mon_on) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        for (int p = 0; p < 2; p++) begin
          cur = (p == 1) ? pend[ch] : tick[ch];
          prv = (p == 1) ? prev_pend[ch] : prev_tick[ch];
          if (cur !== prv) begin
            idx = -1;
            for (int i = 0; i < q.size(); i++)
              if (q[i].c == cyc && q[i].ch == ch && q[i].p == bit'(p)) idx = i;
            n_cmp++;
            if (idx < 0) begin
              n_bad++;
              $display("FAIL unexpected_change cyc=%0d ch=%0d %s got=%0b required=%0b",
                       cyc, ch, (p == 1) ? "pend" : "tick", cur, prv);
            end else begin
              if (q[idx].v !== cur) begin
                n_bad++;
                $display("FAIL edge_value cyc=%0d ch=%0d %s got=%0b required=%0b",
                         cyc, ch, (p == 1) ? "pend" : "tick", cur, q[idx].v);
              end else begin
                $display("event cyc=%0d ch=%0d %s -> %0b ok",
                         cyc, ch, (p == 1) ? "pend" : "tick", cur);
              end
              q.delete(idx);
            end
          end
        end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].c <= cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_edge cyc=%0d ch=%0d %s got=no_change required=%0b",
                   q[i].c, q[i].ch, q[i].p ? "pend" : "tick", q[i].v);
          q.delete(i);
        end
      end
      prev_tick = tick;
      prev_pend = pend;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int s0;
    int y;

    repeat (3) step();
    n_cmp++;
    if (tick !== '0) begin n_bad++; $display("FAIL reset_tick got=%b required=0000", tick); end
    n_cmp++;
    if (pend !== '0) begin n_bad++; $display("FAIL reset_pend got=%b required=0000", pend); end
    prev_tick = tick;
    prev_pend = pend;
    mon_on = 1'b1;
    rst = 1'b0;
    step();

    // default divisor pulses on ch0
    en[0] = 1'b1; s = cyc + 1;
    pulses(0, s + DEF, DEF, 2);
    wait_until(s + 2 * DEF + 50);
    en[0] = 1'b0; step();

    // disabled write goes straight to active: square D=4 on ch1, no pend
    cfg(1, 4, 1);
    en[1] = 1'b1; s = cyc + 1;
    squares(1, s + 4, 4, 4);
    wait_until(s + 18);
    en[1] = 1'b0; step();

    // ch2 D=10, reprogrammed to 3 mid-period
    cfg(2, 10, 0);
    en[2] = 1'b1; s = cyc + 1;
    pulses(2, s + 10, 10, 2);
    push(s + 13, 2, 1'b1, 1'b1);
    push(s + 20, 2, 1'b1, 1'b0);
    pulses(2, s + 23, 3, 3);
    wait_until(s + 12);
    cfg(2, 3, 0);
    wait_until(s + 30);
    en[2] = 1'b0; step();

    // ch3 pulse D=4 switched to square D=2: no output edge at the apply wrap
    cfg(3, 4, 0);
    en[3] = 1'b1; s = cyc + 1;
    pulses(3, s + 4, 4, 1);
    push(s + 6, 3, 1'b1, 1'b1);
    push(s + 8, 3, 1'b1, 1'b0);
    squares(3, s + 10, 2, 4);
    wait_until(s + 5);
    cfg(3, 2, 1);
    wait_until(s + 16);
    en[3] = 1'b0; step();

    // sync realigns ch0 (D=5) and ch1 (D=7)
    cfg(0, 5, 0);
    cfg(1, 7, 0);
    en[0] = 1'b1; s0 = cyc + 1;
    step(); step();
    en[1] = 1'b1;
    pulses(0, s0 + 5, 5, 2);
    pulses(1, s0 + 9, 7, 1);
    y = s0 + 12;
    wait_until(y - 1);
    sync = 1'b1; step(); sync = 1'b0;
    pulses(0, y + 5, 5, 3);
    pulses(1, y + 7, 7, 2);
    wait_until(y + 16);
    en[0] = 1'b0; en[1] = 1'b0; step();

    // out-of-range channel write is ignored
    en[0] = 1'b1; s = cyc + 1;
    pulses(0, s + 5, 5, 2);
    wait_until(s + 2);
    cfg(4, 2, 1);
    wait_until(s + 11);
    en[0] = 1'b0; step();

    // D=0 keeps ch3 silent
    cfg(3, 0, 0);
    en[3] = 1'b1;
    repeat (40) step();
    n_cmp++;
    if (tick[3] !== 1'b0) begin n_bad++; $display("FAIL div0_tick got=%0b required=0", tick[3]); end
    en[3] = 1'b0; step();

    // reset while ch1 square is high and a write is pending
    cfg(1, 4, 1);
    en[1] = 1'b1; s = cyc + 1;
    push(s + 4, 1, 1'b0, 1'b1);
    wait_until(s + 5);
    cfg(1, 6, 1);
    push(s + 6, 1, 1'b1, 1'b1);
    rst = 1'b1;
    push(s + 7, 1, 1'b0, 1'b0);
    push(s + 7, 1, 1'b1, 1'b0);
    step(); step();
    n_cmp++;
    if (tick !== '0 || pend !== '0) begin
      n_bad++;
      $display("FAIL in_reset got=tick %b pend %b required=0000 0000", tick, pend);
    end
    rst = 1'b0; en = '0;
    step(); step();
    en[0] = 1'b1; s = cyc + 1;
    pulses(0, s + DEF, DEF, 2);
    wait_until(s + 2 * DEF + 5);
    en[0] = 1'b0;
    repeat (5) step();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events got=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
